// File: rtl/ceespu_mem_arbiter.sv
// ceespu_mem_arbiter: shares the single data-memory port between the execute
// stage (port 0) and the debug/loader path (port 1). Per-cycle arbitration,
// short locked bursts with a forced release after LOCK_MAX grants, and read
// data routed back to its owner after MEM_LATENCY cycles.
// Optional build macro CEESPU_ARB_ROUND_ROBIN_EN: when both ports request in
// IDLE the port that did not own the last grant wins (default: port 0 wins).

module ceespu_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 1,   // 1..4
    parameter int LOCK_MAX    = 16   // 2..255
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_req0,
    input  logic              I_req1,
    input  logic              I_lock0,
    input  logic              I_lock1,
    input  logic [ADDR_W-1:0] I_addr0,
    input  logic [ADDR_W-1:0] I_addr1,
    input  logic [3:0]        I_we0,
    input  logic [3:0]        I_we1,
    input  logic [31:0]       I_wdata0,
    input  logic [31:0]       I_wdata1,
    output logic              O_gnt0,
    output logic              O_gnt1,
    output logic              O_busy0,
    output logic              O_busy1,
    output logic              O_rvalid0,
    output logic              O_rvalid1,
    output logic [31:0]       O_rdata,
    output logic              O_memE,
    output logic [3:0]        O_memWe,
    output logic [ADDR_W-1:0] O_memAddress,
    output logic [31:0]       O_memData,
    input  logic [31:0]       I_memData
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_last_owner;
    logic                   w_last_owner_nxt;
    logic [7:0]             r_lock_cnt;
    logic [7:0]             w_lock_cnt_nxt;
    logic [7:0]             w_lock_cnt_inc;
    logic                   r_handoff;      // previous cycle ended in a forced release
    logic                   w_handoff_nxt;
    logic                   w_arb_gnt0;
    logic                   w_arb_gnt1;
    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_lock_port;    // port owning the current lock
    logic                   w_lock_req;
    logic                   w_lock_hold;
    logic                   w_rd_push;
    logic [MEM_LATENCY-1:0] r_rd_vld;
    logic [MEM_LATENCY-1:0] r_rd_tag;       // 0 = port 0, 1 = port 1

    assign w_lock_port    = (r_state == ST_LOCK1);
    assign w_lock_req     = w_lock_port ? I_req1  : I_req0;
    assign w_lock_hold    = w_lock_port ? I_lock1 : I_lock0;
    assign w_lock_cnt_inc = r_lock_cnt + 8'd1;

    // Arbitration and next-state logic for the lock FSM.
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_arb_gnt0       = 1'b0;
        w_arb_gnt1       = 1'b0;
        w_state_nxt      = r_state;
        w_lock_cnt_nxt   = r_lock_cnt;
        w_handoff_nxt    = 1'b0;
        w_last_owner_nxt = r_last_owner;

        unique case (r_state)
            ST_IDLE: begin
                if (r_handoff && r_last_owner && I_req0) begin
                    w_arb_gnt0 = 1'b1;
                end else if (r_handoff && !r_last_owner && I_req1) begin
                    w_arb_gnt1 = 1'b1;
                end else if (I_req0 && I_req1) begin
`ifdef CEESPU_ARB_ROUND_ROBIN_EN
                    w_arb_gnt0 = r_last_owner;
                    w_arb_gnt1 = !r_last_owner;
`else
                    w_arb_gnt0 = 1'b1;
`endif
                end else begin
                    w_arb_gnt0 = I_req0;
                    w_arb_gnt1 = I_req1;
                end

                if (w_arb_gnt0 && I_lock0) begin
                    w_state_nxt    = ST_LOCK0;
                    w_lock_cnt_nxt = 8'd1;
                end else if (w_arb_gnt1 && I_lock1) begin
                    w_state_nxt    = ST_LOCK1;
                    w_lock_cnt_nxt = 8'd1;
                end
            end

            ST_LOCK0, ST_LOCK1: begin
                // Only the lock owner may be granted; the other port stalls.
                w_arb_gnt0 = !w_lock_port && w_lock_req;
                w_arb_gnt1 =  w_lock_port && w_lock_req;
                if (!w_lock_req) begin
                    // Owner abandoned the burst.
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = 8'd0;
                end else if (w_lock_cnt_inc == LOCK_MAX_C) begin
                    // Forced release: lock input ignored, other port gets next turn.
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = 8'd0;
                    w_handoff_nxt  = 1'b1;
                end else if (!w_lock_hold) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = 8'd0;
                end else begin
                    w_lock_cnt_nxt = w_lock_cnt_inc;
                end
            end

            default: begin
                w_state_nxt    = ST_IDLE;
                w_lock_cnt_nxt = 8'd0;
            end
        endcase

        if (w_arb_gnt0) begin
            w_last_owner_nxt = 1'b0;
        end else if (w_arb_gnt1) begin
            w_last_owner_nxt = 1'b1;
        end
    end

    // All outputs are held at zero while reset is asserted.
    assign w_gnt0 = w_arb_gnt0 && !I_rst;
    assign w_gnt1 = w_arb_gnt1 && !I_rst;

    assign O_gnt0  = w_gnt0;
    assign O_gnt1  = w_gnt1;
    assign O_busy0 = I_req0 && !w_gnt0 && !I_rst;
    assign O_busy1 = I_req1 && !w_gnt1 && !I_rst;

    // Memory port: combinational mux of the granted requester.
    always_comb begin
        O_memE       = 1'b0;
        O_memWe      = 4'd0;
        O_memAddress = '0;
        O_memData    = 32'd0;
        if (w_gnt0) begin
            O_memE       = 1'b1;
            O_memWe      = I_we0;
            O_memAddress = I_addr0;
            O_memData    = I_wdata0;
        end else if (w_gnt1) begin
            O_memE       = 1'b1;
            O_memWe      = I_we1;
            O_memAddress = I_addr1;
            O_memData    = I_wdata1;
        end
    end

    assign w_rd_push = (w_gnt0 && (I_we0 == 4'd0)) || (w_gnt1 && (I_we1 == 4'd0));

    // FSM state, lock counter, last owner and handoff flag.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
            r_lock_cnt   <= 8'd0;
            r_handoff    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
            r_handoff    <= w_handoff_nxt;
        end
    end

    // Read-return pipeline: one valid/tag pair per cycle of memory latency.
    // NOTE: this shift register is reset so in-flight reads are dropped rather than returned after reset.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_rd_vld <= '0;
            r_rd_tag <= '0;
        end else begin
            r_rd_vld[0] <= w_rd_push;
            r_rd_tag[0] <= w_gnt1;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_rd_vld[i] <= r_rd_vld[i-1];
                r_rd_tag[i] <= r_rd_tag[i-1];
            end
        end
    end

    assign O_rvalid0 = r_rd_vld[MEM_LATENCY-1] && !r_rd_tag[MEM_LATENCY-1];
    assign O_rvalid1 = r_rd_vld[MEM_LATENCY-1] &&  r_rd_tag[MEM_LATENCY-1];
    assign O_rdata   = (O_rvalid0 || O_rvalid1) ? I_memData : 32'd0;

endmodule

// File: tb/tb_ceespu_mem_arbiter.sv
// Testbench for ceespu_mem_arbiter: two instances (MEM_LATENCY 1 and 3,
// LOCK_MAX 4) share one stimulus stream; a transaction-level model predicts
// grants, memory-port values and read returns every cycle.
`timescale 1ns/1ps

module tb_ceespu_mem_arbiter;

    localparam int LOCK_MAX = 4;
    localparam int NDUT     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
    logic [3:0]  we0, we1;

    logic [NDUT-1:0] gnt0, gnt1, busy0, busy1, rvalid0, rvalid1, mem_e;
    logic [3:0]      mem_we    [NDUT];
    logic [31:0]     mem_addr  [NDUT];
    logic [31:0]     mem_wdata [NDUT];
    logic [31:0]     rdata     [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ceespu_mem_arbiter #(.ADDR_W(32), .MEM_LATENCY(1), .LOCK_MAX(LOCK_MAX)) u_dut_l1 (
        .I_clk(clk), .I_rst(rst),
        .I_req0(req0), .I_req1(req1), .I_lock0(lock0), .I_lock1(lock1),
        .I_addr0(addr0), .I_addr1(addr1), .I_we0(we0), .I_we1(we1),
        .I_wdata0(wdata0), .I_wdata1(wdata1),
        .O_gnt0(gnt0[0]), .O_gnt1(gnt1[0]), .O_busy0(busy0[0]), .O_busy1(busy1[0]),
        .O_rvalid0(rvalid0[0]), .O_rvalid1(rvalid1[0]), .O_rdata(rdata[0]),
        .O_memE(mem_e[0]), .O_memWe(mem_we[0]), .O_memAddress(mem_addr[0]),
        .O_memData(mem_wdata[0]), .I_memData(mem_rdata)
    );

    ceespu_mem_arbiter #(.ADDR_W(32), .MEM_LATENCY(3), .LOCK_MAX(LOCK_MAX)) u_dut_l3 (
        .I_clk(clk), .I_rst(rst),
        .I_req0(req0), .I_req1(req1), .I_lock0(lock0), .I_lock1(lock1),
        .I_addr0(addr0), .I_addr1(addr1), .I_we0(we0), .I_we1(we1),
        .I_wdata0(wdata0), .I_wdata1(wdata1),
        .O_gnt0(gnt0[1]), .O_gnt1(gnt1[1]), .O_busy0(busy0[1]), .O_busy1(busy1[1]),
        .O_rvalid0(rvalid0[1]), .O_rvalid1(rvalid1[1]), .O_rdata(rdata[1]),
        .O_memE(mem_e[1]), .O_memWe(mem_we[1]), .O_memAddress(mem_addr[1]),
        .O_memData(mem_wdata[1]), .I_memData(mem_rdata)
    );

    // ---------------- behavioural model ----------------
    int m_lock [NDUT];     // lock owner, -1 = none
    int m_cnt  [NDUT];     // grants so far in the current lock
    int m_last [NDUT];     // last granted port
    int m_hand [NDUT];     // port owed a turn after a forced release, -1 = none
    bit m_rv   [NDUT][8];  // read return scheduled for cycle (index mod 8)
    bit m_rt   [NDUT][8];  // owner of that return
    int m_cyc;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit req_of(input int p);
        return (p == 0) ? req0 : req1;
    endfunction

    function automatic bit lock_of(input int p);
        return (p == 0) ? lock0 : lock1;
    endfunction

    function automatic logic [3:0] we_of(input int p);
        return (p == 0) ? we0 : we1;
    endfunction

    function automatic int exp_grant(input int k);
        if (m_lock[k] >= 0) return req_of(m_lock[k]) ? m_lock[k] : -1;
        if (m_hand[k] >= 0 && req_of(m_hand[k])) return m_hand[k];
        if (req0 && req1) begin
`ifdef CEESPU_ARB_ROUND_ROBIN_EN
            return 1 - m_last[k];
`else
            return 0;
`endif
        end
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_lock[k] = -1;
            m_cnt[k]  = 0;
            m_last[k] = 1;
            m_hand[k] = -1;
            for (int s = 0; s < 8; s++) begin
                m_rv[k][s] = 1'b0;
                m_rt[k][s] = 1'b0;
            end
        end
        m_cyc = 0;
    endtask

    // Advance the model across one rising edge (inputs still stable).
    task automatic model_update();
        for (int k = 0; k < NDUT; k++) begin
            int g;
            int ns;
            g = exp_grant(k);
            m_rv[k][m_cyc % 8] = 1'b0;
            if (g >= 0 && we_of(g) == 4'd0) begin
                ns = (m_cyc + lat(k)) % 8;
                m_rv[k][ns] = 1'b1;
                m_rt[k][ns] = (g == 1);
            end
            if (m_lock[k] >= 0) begin
                int n;
                n = m_lock[k];
                m_hand[k] = -1;
                if (!req_of(n)) begin
                    m_lock[k] = -1;
                end else begin
                    m_cnt[k]++;
                    m_last[k] = n;
                    if (m_cnt[k] == LOCK_MAX) begin
                        m_lock[k] = -1;
                        m_hand[k] = 1 - n;
                    end else if (!lock_of(n)) begin
                        m_lock[k] = -1;
                    end
                end
            end else begin
                m_hand[k] = -1;
                if (g >= 0) begin
                    m_last[k] = g;
                    if (lock_of(g)) begin
                        m_lock[k] = g;
                        m_cnt[k]  = 1;
                    end
                end
            end
        end
        m_cyc++;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic compare_all();
        for (int k = 0; k < NDUT; k++) begin
            int         g;
            bit         erv;
            bit         etag;
            logic [3:0] ewe;
            logic [31:0] ead, ewd;
            g    = exp_grant(k);
            erv  = m_rv[k][m_cyc % 8];
            etag = m_rt[k][m_cyc % 8];
            ewe  = (g == 0) ? we0    : (g == 1) ? we1    : 4'd0;
            ead  = (g == 0) ? addr0  : (g == 1) ? addr1  : 32'd0;
            ewd  = (g == 0) ? wdata0 : (g == 1) ? wdata1 : 32'd0;
            check($sformatf("d%0d gnt0", k),   gnt0[k],      g == 0);
            check($sformatf("d%0d gnt1", k),   gnt1[k],      g == 1);
            check($sformatf("d%0d busy0", k),  busy0[k],     req0 && g != 0);
            check($sformatf("d%0d busy1", k),  busy1[k],     req1 && g != 1);
            check($sformatf("d%0d memE", k),   mem_e[k],     g >= 0);
            check($sformatf("d%0d memWe", k),  mem_we[k],    ewe);
            check($sformatf("d%0d memAddr", k), mem_addr[k], ead);
            check($sformatf("d%0d memData", k), mem_wdata[k], ewd);
            check($sformatf("d%0d rvalid0", k), rvalid0[k],  erv && !etag);
            check($sformatf("d%0d rvalid1", k), rvalid1[k],  erv && etag);
            check($sformatf("d%0d rdata", k),  rdata[k],     erv ? mem_rdata : 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("%s d%0d outs", tag, k),
                  {gnt0[k], gnt1[k], busy0[k], busy1[k], rvalid0[k], rvalid1[k], mem_e[k]}, 64'd0);
            check($sformatf("%s d%0d memWe/rdata", tag, k), {mem_we[k], rdata[k]}, 64'd0);
            check($sformatf("%s d%0d memAddr/Data", tag, k), {mem_addr[k], mem_wdata[k]}, 64'd0);
        end
    endtask

    task automatic set_idle();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        we0 = 4'd0; we1 = 4'd0; addr0 = 32'd0; addr1 = 32'd0;
        wdata0 = 32'd0; wdata1 = 32'd0;
    endtask

    task automatic step_begin();
        @(negedge clk);
        compare_all();
    endtask

    task automatic step_end();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Asynchronous reset pulse between edges, with requests held to prove gating.
    task automatic reset_pulse();
        #2;
        req0 = 1'b1; req1 = 1'b1;
        rst  = 1'b1;
        #1;
        check_all_zero("rst");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("rst hold");
        set_idle();
        #3;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        mem_rdata = 32'd0;
        rst = 1'b1;
        model_reset();
        #2;
        req0 = 1'b1; req1 = 1'b1; we0 = 4'hF; addr0 = 32'h44;
        #1;
        check_all_zero("reset");
        set_idle();
        #9;
        rst = 1'b0;
        step_end();

        // Port 0 write, port 1 idle.
        req0 = 1'b1; addr0 = 32'h100; we0 = 4'b1111; wdata0 = 32'hDEADBEEF;
        step_begin();
        check("t1 gnt0",   gnt0[0], 1'b1);
        check("t1 memE",   mem_e[0], 1'b1);
        check("t1 memWe",  mem_we[0], 4'b1111);
        check("t1 memAddr", mem_addr[0], 32'h100);
        check("t1 memData", mem_wdata[0], 32'hDEADBEEF);
        check("t1 busy0",  busy0[0], 1'b0);
        step_end();

        // Port 1 read of 0x40, data returns one cycle later on the latency-1 instance.
        set_idle();
        req1 = 1'b1; addr1 = 32'h40;
        step_begin();
        check("t2 gnt1", gnt1[0], 1'b1);
        step_end();
        set_idle();
        mem_rdata = 32'h12345678;
        step_begin();
        check("t2 rvalid1", rvalid1[0], 1'b1);
        check("t2 rdata",   rdata[0], 32'h12345678);
        check("t2 rvalid0", rvalid0[0], 1'b0);
        step_end();

        // Both ports read for 4 cycles.
        for (int i = 0; i < 5; i++) begin
            set_idle();
            if (i < 4) begin
                req0 = 1'b1; req1 = 1'b1; addr0 = 32'h200 + i; addr1 = 32'h300 + i;
            end
            mem_rdata = 32'hA000_0000 + i;
            step_begin();
            if (i < 4) begin
`ifdef CEESPU_ARB_ROUND_ROBIN_EN
                check("t3 gnt0 rr", gnt0[0], (i % 2) == 0);
                check("t3 gnt1 rr", gnt1[0], (i % 2) == 1);
`else
                check("t3 gnt0", gnt0[0], 1'b1);
                check("t3 busy1", busy1[0], 1'b1);
`endif
            end
            if (i > 0) begin
`ifdef CEESPU_ARB_ROUND_ROBIN_EN
                check("t3 rvalid0 rr", rvalid0[0], ((i - 1) % 2) == 0);
`else
                check("t3 rvalid0", rvalid0[0], 1'b1);
`endif
            end
            step_end();
        end

        // Port 1 locked burst with port 0 waiting: 4 grants, then forced handoff.
        for (int i = 0; i < 6; i++) begin
            set_idle();
            req1 = (i < 5); lock1 = 1'b1; we1 = 4'h3; addr1 = 32'h500 + i;
            req0 = (i > 0); addr0 = 32'h600;
            step_begin();
            if (i < 4) check("t4 gnt1 locked", gnt1[0], 1'b1);
            if (i >= 1 && i < 4) check("t4 busy0", busy0[0], 1'b1);
            if (i == 4) begin
                check("t4 gnt0 handoff", gnt0[0], 1'b1);
                check("t4 gnt1 released", gnt1[0], 1'b0);
            end
            step_end();
        end

        // Port 0 locks, abandons for a cycle while port 1 waits.
        for (int i = 0; i < 4; i++) begin
            set_idle();
            req0 = (i < 2); lock0 = 1'b1; we0 = 4'h1;
            req1 = (i > 0); addr1 = 32'h700;
            step_begin();
            if (i == 2) begin
                check("t5 gnt1 stalled", gnt1[0], 1'b0);
                check("t5 busy1 stalled", busy1[0], 1'b1);
            end
            if (i == 3) check("t5 gnt1 after abandon", gnt1[0], 1'b1);
            step_end();
        end

        // Port 0 read on the latency-3 instance, reset mid-flight.
        set_idle();
        req0 = 1'b1; addr0 = 32'h80;
        step_begin();
        check("t6 gnt0", gnt0[1], 1'b1);
        step_end();
        set_idle();
        step_begin();
        reset_pulse();
        step_end();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            mem_rdata = 32'hCAFE_0000 + i;
            step_begin();
            check("t6 no rvalid0 after reset", rvalid0[1], 1'b0);
            step_end();
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            req0   = ($urandom_range(0, 3) != 0);
            req1   = ($urandom_range(0, 2) != 0);
            lock0  = ($urandom_range(0, 2) == 0);
            lock1  = ($urandom_range(0, 2) == 0);
            we0    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            we1    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            addr0  = $urandom;
            addr1  = $urandom;
            wdata0 = $urandom;
            wdata1 = $urandom;
            mem_rdata = $urandom;
            step_begin();
            if ($urandom_range(0, 399) == 0) reset_pulse();
            step_end();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
